// File: rtl/w6_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w6_pkg : shared state encoding, field widths and frame packing for w6host
// Rev 1.0
// ---------------------------------------------------------------------------
package w6_pkg;

  localparam int W6_ADDR_W     = 8;
  localparam int W6_DATA_W     = 64;
  localparam int W6_FRAME_BITS = W6_ADDR_W + W6_DATA_W;
  localparam int W6_STATUS_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TURN  = 3'd3,
    ST_READ  = 3'd4,
    ST_GAP   = 3'd5
  } w6_state_e;

  // Address leads the frame so it reaches the device first when shifted MSB first.
  function automatic logic [W6_FRAME_BITS-1:0] w6_pack(
    input logic [W6_ADDR_W-1:0] addr,
    input logic [W6_DATA_W-1:0] data
  );
    return {addr, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/w6host_bitclk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w6host_bitclk : link bit-clock divider with phase strobes; io_clk held low when disabled
// Rev 1.0
// ---------------------------------------------------------------------------
module w6host_bitclk #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic io_clk,
  output logic fall_stb,
  output logic rise_stb,
  output logic last_hi_stb
);

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLKDIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_hi  <= 1'b0;
    end else if (!en) begin
      r_div <= '0;
      r_hi  <= 1'b0;
    end else if (r_div == c_div_last) begin
      r_div <= '0;
      r_hi  <= ~r_hi;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign io_clk      = r_hi;
  assign fall_stb    = en && !r_hi && (r_div == '0);
  assign rise_stb    = en &&  r_hi && (r_div == '0);
  assign last_hi_stb = en &&  r_hi && (r_div == c_div_last);

endmodule
`default_nettype wire

// File: rtl/w6host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w6host : w6 debug link host master; 72-bit frames out, optional status readback
//          (readback built when W6HOST_READBACK_EN is defined)
// Rev 1.0
// ---------------------------------------------------------------------------
module w6host
  import w6_pkg::*;
#(
  parameter int CLKDIV      = 4,
  parameter int CTS_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [W6_ADDR_W-1:0]   cmd_addr,
  input  logic [W6_DATA_W-1:0]   cmd_data,
  output logic                   tx_done,
  output logic                   err_timeout,
  output logic                   rsp_valid,
  output logic [W6_STATUS_W-1:0] rsp_status,
  output logic                   io_clk,
  output logic                   io_dir,
  output logic                   io_rts,
  input  logic                   io_cts,
  output logic                   io_in,
  input  logic                   io_out
);

  localparam int TMO_W = $clog2(CTS_TIMEOUT + 1);
  localparam int GAP_W = $clog2(CLKDIV + 1);
  localparam logic [TMO_W-1:0] c_tmo_max    = TMO_W'(CTS_TIMEOUT);
  localparam logic [GAP_W-1:0] c_gap_last   = GAP_W'(CLKDIV);
  localparam logic [6:0]       c_frame_last = 7'(W6_FRAME_BITS - 1);

  w6_state_e                r_state, w_next;
  logic                     r_cts_meta, r_cts_sync;
  logic [W6_FRAME_BITS-1:0] r_sh;
  logic [6:0]               r_bit;
  logic [TMO_W-1:0]         r_tmo;
  logic [GAP_W-1:0]         r_gap;
  logic                     w_bclk_en, w_fall_stb, w_rise_stb, w_last_hi;
  logic                     w_tmo_hit, w_bit_last, w_unused;

  w6host_bitclk #(.CLKDIV(CLKDIV)) u_bitclk (
    .clk         (clk),
    .rst         (rst),
    .en          (w_bclk_en),
    .io_clk      (io_clk),
    .fall_stb    (w_fall_stb),
    .rise_stb    (w_rise_stb),
    .last_hi_stb (w_last_hi)
  );

  assign w_tmo_hit  = !r_cts_sync && (r_tmo == c_tmo_max);
  assign w_bit_last = w_last_hi && (r_bit == 7'd0);

  always_comb begin
    w_next      = r_state;
    cmd_ready   = 1'b0;
    tx_done     = 1'b0;
    err_timeout = 1'b0;
    io_rts      = 1'b0;
    io_in       = 1'b0;
    io_dir      = 1'b1;
    w_bclk_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = ST_REQ;
      end
      ST_REQ: begin
        // A grant on the same cycle as the limit still wins.
        io_rts      = r_cts_sync || !w_tmo_hit;
        err_timeout = !r_cts_sync && w_tmo_hit;
        if (r_cts_sync)     w_next = ST_SHIFT;
        else if (w_tmo_hit) w_next = ST_IDLE;
      end
      ST_SHIFT: begin
        io_rts    = 1'b1;
        io_in     = r_sh[W6_FRAME_BITS-1];
        w_bclk_en = 1'b1;
`ifdef W6HOST_READBACK_EN
        if (w_bit_last) w_next = ST_TURN;
`else
        if (w_bit_last) w_next = ST_GAP;
`endif
      end
`ifdef W6HOST_READBACK_EN
      ST_TURN: begin
        io_dir = 1'b0;
        if (r_gap == GAP_W'(CLKDIV - 1)) w_next = ST_READ;
      end
      ST_READ: begin
        io_dir    = 1'b0;
        w_bclk_en = 1'b1;
        if (w_bit_last) w_next = ST_GAP;
      end
`endif
      ST_GAP: begin
        // Idle-low guard of CLKDIV+1 cycles; tx_done marks its final cycle.
        if (r_gap == c_gap_last) begin
          tx_done = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cts_meta <= 1'b0;
      r_cts_sync <= 1'b0;
      r_sh       <= '0;
      r_bit      <= '0;
      r_tmo      <= '0;
      r_gap      <= '0;
    end else begin
      r_state    <= w_next;
      r_cts_meta <= io_cts;
      r_cts_sync <= r_cts_meta;

      if (r_state == ST_IDLE && cmd_valid) begin
        r_sh  <= w6_pack(cmd_addr, cmd_data);
        r_bit <= c_frame_last;
        r_tmo <= '0;
      end else if (r_state == ST_REQ && r_tmo != c_tmo_max) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end

      if (r_state == ST_SHIFT && w_last_hi)
        r_sh <= {r_sh[W6_FRAME_BITS-2:0], 1'b0};

      if (r_state == ST_TURN)
        r_bit <= 7'(W6_STATUS_W - 1);
      else if ((r_state == ST_SHIFT || r_state == ST_READ) && w_last_hi)
        r_bit <= r_bit - 7'd1;

      if ((r_state == ST_GAP || r_state == ST_TURN) && w_next == r_state)
        r_gap <= r_gap + GAP_W'(1);
      else
        r_gap <= '0;
    end
  end

`ifdef W6HOST_READBACK_EN
  logic [W6_STATUS_W-1:0] r_rsp_sh, r_rsp_status;
  logic                   r_rsp_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_sh     <= '0;
      r_rsp_status <= '0;
      r_rsp_valid  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_state == ST_READ && w_last_hi) begin
        r_rsp_sh <= {r_rsp_sh[W6_STATUS_W-2:0], io_out};
        if (r_bit == 7'd0) begin
          r_rsp_status <= {r_rsp_sh[W6_STATUS_W-2:0], io_out};
          r_rsp_valid  <= 1'b1;
        end
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_status = r_rsp_status;
  assign w_unused   = ^{w_fall_stb, w_rise_stb};
`else
  assign rsp_valid  = 1'b0;
  assign rsp_status = '0;
  assign w_unused   = ^{w_fall_stb, w_rise_stb, io_out};
`endif

endmodule
`default_nettype wire

// File: tb/tb_w6host.sv
`timescale 1ns/1ps
`default_nettype none
// tb_w6host : directed self-checking bench for w6host (CLKDIV=4, CTS_TIMEOUT=16)
module tb_w6host;

  localparam int CLKDIV      = 4;
  localparam int CTS_TIMEOUT = 16;
  localparam int MAXCYC      = 3000;

  logic        clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        cmd_ready, tx_done, err_timeout, rsp_valid;
  logic [7:0]  rsp_status;
  logic        io_clk, io_dir, io_rts, io_in;
  logic        io_cts = 1'b0, io_out = 1'b0;
  int          n_checks = 0, n_pass = 0;

  w6host #(.CLKDIV(CLKDIV), .CTS_TIMEOUT(CTS_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .tx_done(tx_done),
    .err_timeout(err_timeout), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .io_clk(io_clk), .io_dir(io_dir), .io_rts(io_rts), .io_cts(io_cts),
    .io_in(io_in), .io_out(io_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and follows the frame until tx_done; cycle 1 is the cycle after accept.
  task automatic run_frame(
    input  logic [7:0]  addr,
    input  logic [63:0] data,
    input  int          drop_bit,
    input  logic [7:0]  dev_status,
    output logic [71:0] bits,
    output int          nbits,
    output int          rts_rise_cyc,
    output int          rise_cyc,
    output int          rts_fall_cyc,
    output int          done_cyc,
    output int          unstable,
    output int          nread,
    output int          rsp_cyc,
    output logic [7:0]  rsp_val,
    output int          dir0_cyc
  );
    logic prev_clk, prev_rts, cur_bit;
    int   cyc, k;
    bits = '0; nbits = 0; rts_rise_cyc = -1; rise_cyc = -1; rts_fall_cyc = -1;
    done_cyc = -1; unstable = 0; nread = 0; rsp_cyc = -1; rsp_val = '0; dir0_cyc = 0;
    k = 0;
    while (!cmd_ready && k < 100) begin step(); k++; end
    cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cyc = 1; prev_clk = 1'b0; prev_rts = 1'b0; cur_bit = 1'b0;
    while (cyc < MAXCYC && done_cyc < 0) begin
      if (!prev_clk && io_clk) begin
        if (rise_cyc < 0) rise_cyc = cyc;
        if (io_dir) begin
          bits = {bits[70:0], io_in};
          nbits++;
          cur_bit = io_in;
          if (nbits == drop_bit) io_cts = 1'b0;
        end else begin
          if (nread < 8) io_out = dev_status[7-nread];
          nread++;
        end
      end
      if (io_clk && io_dir && io_in !== cur_bit) unstable++;
      if (!io_dir) dir0_cyc++;
      if (io_rts && rts_rise_cyc < 0) rts_rise_cyc = cyc;
      if (prev_rts && !io_rts && rts_fall_cyc < 0) rts_fall_cyc = cyc;
      if (rsp_valid) begin rsp_cyc = cyc; rsp_val = rsp_status; end
      if (tx_done) done_cyc = cyc;
      prev_clk = io_clk; prev_rts = io_rts;
      if (done_cyc < 0) begin step(); cyc++; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b1; cmd_addr = 8'hFF; io_cts = 1'b1;
    repeat (3) step();
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    n_checks++; if (tx_done !== 1'b0) $display("FAIL reset_tx_done: got %b want 0", tx_done); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err_timeout: got %b want 0", err_timeout); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_status !== 8'h00) $display("FAIL reset_rsp_status: got %h want 00", rsp_status); else n_pass++;
    n_checks++; if (io_clk !== 1'b0) $display("FAIL reset_io_clk: got %b want 0", io_clk); else n_pass++;
    n_checks++; if (io_dir !== 1'b1) $display("FAIL reset_io_dir: got %b want 1", io_dir); else n_pass++;
    n_checks++; if (io_rts !== 1'b0) $display("FAIL reset_io_rts: got %b want 0", io_rts); else n_pass++;
    n_checks++; if (io_in !== 1'b0) $display("FAIL reset_io_in: got %b want 0", io_in); else n_pass++;
    cmd_valid = 1'b0; rst = 1'b1;
    step(); step();
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmd_ready); else n_pass++;
    n_checks++; if (io_rts !== 1'b0) $display("FAIL reset_release_rts: got %b want 0", io_rts); else n_pass++;
  endtask

  task automatic test_frame();
    logic [71:0] bits; logic [7:0] rv;
    int nb, rr, rc, rf, dc, us, nr, rsc, d0;
    run_frame(8'h5A, 64'h0123_4567_89AB_CDEF, -1, 8'h00, bits, nb, rr, rc, rf, dc, us, nr, rsc, rv, d0);
    n_checks++; if (bits !== 72'h5A_0123_4567_89AB_CDEF) $display("FAIL frame_bits: got %h want 5a0123456789abcdef", bits); else n_pass++;
    n_checks++; if (nb !== 72) $display("FAIL frame_nbits: got %0d want 72", nb); else n_pass++;
    n_checks++; if (rr !== 1) $display("FAIL frame_rts_rise: got cycle %0d want 1", rr); else n_pass++;
    n_checks++; if (rc !== 6) $display("FAIL frame_first_rise: got cycle %0d want 6", rc); else n_pass++;
    n_checks++; if (rf !== 578) $display("FAIL frame_shift_len: rts fell at %0d want 578 (576 SHIFT cycles)", rf); else n_pass++;
    n_checks++; if (dc !== 582) $display("FAIL frame_tx_done: got cycle %0d want 582", dc); else n_pass++;
    n_checks++; if (us !== 0) $display("FAIL frame_io_in_stable: got %0d unstable cycles want 0", us); else n_pass++;
    step();
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL frame_ready_after: got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_timeout();
    int err_cyc, n_err, clk_seen;
    logic rts16, rts17, rdy17, rdy18;
    err_cyc = -1; n_err = 0; clk_seen = 0; rts16 = 1'b0; rts17 = 1'b1; rdy17 = 1'b1; rdy18 = 1'b0;
    io_cts = 1'b0;
    repeat (3) step();
    cmd_addr = 8'h33; cmd_data = 64'h1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (err_timeout) begin n_err++; if (err_cyc < 0) err_cyc = cyc; end
      if (io_clk) clk_seen++;
      if (cyc == 16) rts16 = io_rts;
      if (cyc == 17) begin rts17 = io_rts; rdy17 = cmd_ready; end
      if (cyc == 18) rdy18 = cmd_ready;
      step();
    end
    n_checks++; if (err_cyc !== 17) $display("FAIL timeout_cycle: got %0d want 17", err_cyc); else n_pass++;
    n_checks++; if (n_err !== 1) $display("FAIL timeout_pulse_len: got %0d want 1", n_err); else n_pass++;
    n_checks++; if (rts16 !== 1'b1) $display("FAIL timeout_rts_before: got %b want 1", rts16); else n_pass++;
    n_checks++; if (rts17 !== 1'b0) $display("FAIL timeout_rts_at_err: got %b want 0", rts17); else n_pass++;
    n_checks++; if (clk_seen !== 0) $display("FAIL timeout_io_clk: got %0d high cycles want 0", clk_seen); else n_pass++;
    n_checks++; if ({rdy17, rdy18} !== 2'b01) $display("FAIL timeout_ready: got %b%b want 01", rdy17, rdy18); else n_pass++;
    io_cts = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_cts_drop();
    logic [71:0] bits; logic [7:0] rv;
    int nb, rr, rc, rf, dc, us, nr, rsc, d0;
    run_frame(8'hA5, 64'hFEDC_BA98_7654_3210, 30, 8'h00, bits, nb, rr, rc, rf, dc, us, nr, rsc, rv, d0);
    n_checks++; if (bits !== 72'hA5_FEDC_BA98_7654_3210) $display("FAIL drop_bits: got %h want a5fedcba9876543210", bits); else n_pass++;
    n_checks++; if (nb !== 72) $display("FAIL drop_nbits: got %0d want 72", nb); else n_pass++;
    n_checks++; if (dc !== 582) $display("FAIL drop_tx_done: got cycle %0d want 582", dc); else n_pass++;
    io_cts = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_rst_mid();
    logic [71:0] bits; logic [7:0] rv;
    int nb, rr, rc, rf, dc, us, nr, rsc, d0, nrise, saw_done;
    logic pc;
    nrise = 0; saw_done = 0; pc = 1'b0;
    cmd_addr = 8'h3C; cmd_data = 64'hFFFF_FFFF_FFFF_FFFF; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc < 1000 && nrise < 40; cyc++) begin
      if (!pc && io_clk) nrise++;
      pc = io_clk;
      if (nrise < 40) step();
    end
    n_checks++; if (nrise !== 40) $display("FAIL rstmid_reach_bit40: got %0d rises want 40", nrise); else n_pass++;
    n_checks++; if (io_in !== 1'b1) $display("FAIL rstmid_io_in_before: got %b want 1", io_in); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (io_clk !== 1'b0) $display("FAIL rstmid_io_clk: got %b want 0", io_clk); else n_pass++;
    n_checks++; if (io_rts !== 1'b0) $display("FAIL rstmid_io_rts: got %b want 0", io_rts); else n_pass++;
    n_checks++; if (io_in !== 1'b0) $display("FAIL rstmid_io_in: got %b want 0", io_in); else n_pass++;
    n_checks++; if (io_dir !== 1'b1) $display("FAIL rstmid_io_dir: got %b want 1", io_dir); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (tx_done) saw_done++;
      step();
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (tx_done) saw_done++;
      step();
    end
    n_checks++; if (saw_done !== 0) $display("FAIL rstmid_no_tx_done: got %0d pulses want 0", saw_done); else n_pass++;
    run_frame(8'hC7, 64'h0F0F_0000_FFFF_1234, -1, 8'h00, bits, nb, rr, rc, rf, dc, us, nr, rsc, rv, d0);
    n_checks++; if (bits !== 72'hC7_0F0F_0000_FFFF_1234) $display("FAIL rstmid_next_bits: got %h want c70f0f0000ffff1234", bits); else n_pass++;
    n_checks++; if (dc !== 582) $display("FAIL rstmid_next_done: got cycle %0d want 582", dc); else n_pass++;
    step();
  endtask

  task automatic test_readback();
    logic [71:0] bits; logic [7:0] rv;
    int nb, rr, rc, rf, dc, us, nr, rsc, d0;
    run_frame(8'h81, 64'h0, -1, 8'hC3, bits, nb, rr, rc, rf, dc, us, nr, rsc, rv, d0);
    n_checks++; if (bits !== 72'h81_0000_0000_0000_0000) $display("FAIL rb_bits: got %h want 810000000000000000", bits); else n_pass++;
`ifdef W6HOST_READBACK_EN
    n_checks++; if (nr !== 8) $display("FAIL rb_read_bits: got %0d want 8", nr); else n_pass++;
    n_checks++; if (d0 !== 68) $display("FAIL rb_dir_low: got %0d cycles want 68", d0); else n_pass++;
    n_checks++; if (rv !== 8'hC3) $display("FAIL rb_status: got %h want c3", rv); else n_pass++;
    n_checks++; if (rsc !== 646) $display("FAIL rb_rsp_cycle: got %0d want 646", rsc); else n_pass++;
    n_checks++; if (dc !== 650) $display("FAIL rb_tx_done: got cycle %0d want 650", dc); else n_pass++;
`else
    n_checks++; if (d0 !== 0) $display("FAIL norb_dir_low: got %0d cycles want 0", d0); else n_pass++;
    n_checks++; if (rsc !== -1) $display("FAIL norb_rsp_valid: got pulse at %0d want none", rsc); else n_pass++;
    n_checks++; if (rsp_status !== 8'h00) $display("FAIL norb_rsp_status: got %h want 00", rsp_status); else n_pass++;
    n_checks++; if (dc !== 582) $display("FAIL norb_tx_done: got cycle %0d want 582", dc); else n_pass++;
`endif
    step();
  endtask

  task automatic test_back_to_back();
    int          acc_cyc[2];
    int          nacc, n_done, td1, last_fall, first_rise2, n2;
    logic        pc, acc_now;
    logic [71:0] f2;
    acc_cyc[0] = -1; acc_cyc[1] = -1;
    nacc = 0; n_done = 0; td1 = -1; last_fall = -1; first_rise2 = -1; n2 = 0; pc = 1'b0; f2 = '0;
    cmd_addr = 8'h11; cmd_data = 64'h1111_2222_3333_4444; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 1400 && n_done < 2; cyc++) begin
      acc_now = cmd_valid && cmd_ready;
      if (acc_now) begin
        if (nacc < 2) acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (tx_done) begin
        if (n_done == 0) td1 = cyc;
        n_done++;
      end
      if (nacc == 1 && pc && !io_clk) last_fall = cyc;
      if (nacc == 2 && !pc && io_clk) begin
        if (first_rise2 < 0) first_rise2 = cyc;
        f2 = {f2[70:0], io_in};
        n2++;
      end
      pc = io_clk;
      step();
      if (acc_now) begin
        if (nacc == 1) begin
          cmd_addr = 8'h22; cmd_data = 64'h2222_3333_4444_5555;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    n_checks++; if (acc_cyc[0] !== 0) $display("FAIL b2b_first_accept: got cycle %0d want 0", acc_cyc[0]); else n_pass++;
    n_checks++; if (td1 !== 582) $display("FAIL b2b_first_done: got cycle %0d want 582", td1); else n_pass++;
    n_checks++; if (acc_cyc[1] !== td1 + 1) $display("FAIL b2b_second_accept: got cycle %0d want %0d", acc_cyc[1], td1 + 1); else n_pass++;
    n_checks++; if (first_rise2 - last_fall < CLKDIV + 1) $display("FAIL b2b_gap: got %0d low cycles want >= %0d", first_rise2 - last_fall, CLKDIV + 1); else n_pass++;
    n_checks++; if (f2 !== 72'h22_2222_3333_4444_5555 || n2 !== 72) $display("FAIL b2b_second_bits: got %h (%0d bits) want 2222223333444455 55 (72 bits)", f2, n2); else n_pass++;
    n_checks++; if (n_done !== 2) $display("FAIL b2b_done_count: got %0d want 2", n_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_timeout();
    test_cts_drop();
    test_rst_mid();
    test_readback();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
